// File: rtl/intersection_phase_scheduler.sv
// Round-robin green-phase scheduler for an N-approach signalized intersection.
// Optional emergency preemption is compiled in with `define PREEMPT_EN.
module intersection_phase_scheduler #(
  parameter int NUM_APPR  = 4,
  parameter int TW        = 8,
  parameter int MIN_GREEN = 5,
  parameter int MAX_GREEN = 20,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_APPR-1:0]         req,
  output logic [2*NUM_APPR-1:0]       lights,
  output logic [$clog2(NUM_APPR)-1:0] grant_idx,
  output logic                        phase_start
`ifdef PREEMPT_EN
  ,
  input  logic                        preempt,
  input  logic [$clog2(NUM_APPR)-1:0] preempt_idx
`endif
);

  // state   | meaning
  // ALLRED  | every head red; arbitrates once clearance has elapsed
  // GREEN   | head cur green; ends on gap-out (>= MIN_GREEN) or max-out
  // YELLOW  | head cur yellow for YELLOW_T cycles
  typedef enum logic [1:0] {S_ALLRED, S_GREEN, S_YELLOW} state_t;

  localparam int IW = $clog2(NUM_APPR);
  localparam logic [TW-1:0] ALLRED_LAST = TW'(ALLRED_T - 1);
  localparam logic [TW-1:0] YELLOW_LAST = TW'(YELLOW_T - 1);
  localparam logic [TW:0]   MIN_N       = (TW+1)'(MIN_GREEN);
  localparam logic [TW:0]   MAX_N       = (TW+1)'(MAX_GREEN);

  state_t                state_q, state_d;
  logic [TW-1:0]         cnt_q;
  logic [TW:0]           n;
  logic [IW-1:0]         cur_q, cur_d, win, sel;
  logic                  found, other_req, go_yellow, ps_d;
  logic [NUM_APPR-1:0]   cur_onehot;
  logic [2*NUM_APPR-1:0] lights_d;
  logic [1:0]            head_d;

  assign n          = {1'b0, cnt_q} + (TW+1)'(1);
  assign cur_onehot = NUM_APPR'(1) << cur_q;
  assign other_req  = |(req & ~cur_onehot);

  // Search cur+1, cur+2, ... wrapping; cur itself is visited last.
  always_comb begin
    found = 1'b0;
    win   = cur_q;
    sel   = cur_q;
    for (int k = 1; k <= NUM_APPR; k++) begin
      sel = IW'((int'(cur_q) + k) % NUM_APPR);
      if (!found && req[sel]) begin
        found = 1'b1;
        win   = sel;
      end
    end
`ifdef PREEMPT_EN
    if (preempt && (int'(preempt_idx) < NUM_APPR)) begin
      found = 1'b1;
      win   = preempt_idx;
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    go_yellow = ((n >= MIN_N) && !req[cur_q]) || ((n >= MAX_N) && other_req);
`ifdef PREEMPT_EN
    if (preempt) go_yellow = (preempt_idx != cur_q);
`endif
    case (state_q)
      S_ALLRED: begin
        if ((cnt_q >= ALLRED_LAST) && found) begin
          state_d = S_GREEN;
          cur_d   = win;
        end
      end
      S_GREEN: begin
        if (go_yellow) state_d = S_YELLOW;
      end
      S_YELLOW: begin
        if (cnt_q >= YELLOW_LAST) state_d = S_ALLRED;
      end
      default: state_d = S_ALLRED;
    endcase
  end

  // Outputs are decoded from the next state so they register on the same edge.
  always_comb begin
    lights_d = '0;
    head_d   = 2'd0;
    if (state_d == S_GREEN)  head_d = 2'd2;
    if (state_d == S_YELLOW) head_d = 2'd1;
    for (int i = 0; i < NUM_APPR; i++) begin
      if (cur_d == IW'(i)) lights_d[2*i +: 2] = head_d;
    end
    ps_d = (state_q != S_GREEN) && (state_d == S_GREEN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_ALLRED;
      cnt_q       <= '0;
      cur_q       <= IW'(NUM_APPR - 1);
      lights      <= '0;
      grant_idx   <= IW'(NUM_APPR - 1);
      phase_start <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      if (state_d != state_q) cnt_q <= '0;
      else if (cnt_q != '1)   cnt_q <= cnt_q + TW'(1);
      lights      <= lights_d;
      grant_idx   <= cur_d;
      phase_start <= ps_d;
    end
  end

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Bench for intersection_phase_scheduler at default parameters: segment table
// of {inputs, cycles, expected outputs} fed through a scoreboard queue.
module tb_intersection_phase_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = '0;
  logic [7:0] lights;
  logic [1:0] grant_idx;
  logic       phase_start;
`ifdef PREEMPT_EN
  logic       preempt = 1'b0;
  logic [1:0] preempt_idx = '0;
`endif

  intersection_phase_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .lights      (lights),
    .grant_idx   (grant_idx),
    .phase_start (phase_start)
`ifdef PREEMPT_EN
    ,
    .preempt     (preempt),
    .preempt_idx (preempt_idx)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic [3:0] req;
    int         n;
    logic [7:0] lights;
    logic [1:0] grant;
    logic       ps;
  } seg_t;

  typedef struct packed {
    logic [7:0] lights;
    logic [1:0] grant;
    logic       ps;
  } exp_t;

  seg_t tbl[$];
  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic step(input logic r, input logic [3:0] q, input exp_t e, input string name);
    exp_t x;
    int   lit;
    reset = r;
    req   = q;
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    vectors++;
    if (lights !== x.lights || grant_idx !== x.grant || phase_start !== x.ps) begin
      miscompares++;
      $display("FAIL %s: lights=%h want %h, grant_idx=%0d want %0d, phase_start=%0b want %0b",
               name, lights, x.lights, grant_idx, x.grant, phase_start, x.ps);
    end
    lit = 0;
    for (int i = 0; i < 4; i++) if (lights[2*i +: 2] != 2'd0) lit++;
    if (lit > 1) begin
      miscompares++;
      $display("FAIL %s one_head: %0d non-red heads, want at most 1 (lights=%h)", name, lit, lights);
    end
  endtask

  initial begin
    // reset and idle
    tbl.push_back('{1'b1, 4'b0000,  2, 8'h00, 2'd3, 1'b0});
    tbl.push_back('{1'b0, 4'b0000, 10, 8'h00, 2'd3, 1'b0});
    // single pulsed request on approach 2: 5 green, 2 yellow, all-red
    tbl.push_back('{1'b0, 4'b0100,  1, 8'h20, 2'd2, 1'b1});
    tbl.push_back('{1'b0, 4'b0000,  4, 8'h20, 2'd2, 1'b0});
    tbl.push_back('{1'b0, 4'b0000,  2, 8'h10, 2'd2, 1'b0});
    tbl.push_back('{1'b0, 4'b0000,  5, 8'h00, 2'd2, 1'b0});
    // round-robin 0,1,3,0 with continuous competition
    tbl.push_back('{1'b1, 4'b0000,  1, 8'h00, 2'd3, 1'b0});
    tbl.push_back('{1'b0, 4'b1011,  2, 8'h00, 2'd3, 1'b0});
    tbl.push_back('{1'b0, 4'b1011,  1, 8'h02, 2'd0, 1'b1});
    tbl.push_back('{1'b0, 4'b1011, 19, 8'h02, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 4'b1011,  2, 8'h01, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 4'b1011,  3, 8'h00, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 4'b1011,  1, 8'h08, 2'd1, 1'b1});
    tbl.push_back('{1'b0, 4'b1011, 19, 8'h08, 2'd1, 1'b0});
    tbl.push_back('{1'b0, 4'b1011,  2, 8'h04, 2'd1, 1'b0});
    tbl.push_back('{1'b0, 4'b1011,  3, 8'h00, 2'd1, 1'b0});
    tbl.push_back('{1'b0, 4'b1011,  1, 8'h80, 2'd3, 1'b1});
    tbl.push_back('{1'b0, 4'b1011, 19, 8'h80, 2'd3, 1'b0});
    tbl.push_back('{1'b0, 4'b1011,  2, 8'h40, 2'd3, 1'b0});
    tbl.push_back('{1'b0, 4'b1011,  3, 8'h00, 2'd3, 1'b0});
    tbl.push_back('{1'b0, 4'b1011,  1, 8'h02, 2'd0, 1'b1});
    // own request drops exactly at max-out: one yellow transition
    tbl.push_back('{1'b0, 4'b1011, 19, 8'h02, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 4'b1010,  2, 8'h01, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 4'b1010,  3, 8'h00, 2'd0, 1'b0});
    tbl.push_back('{1'b0, 4'b1010,  1, 8'h08, 2'd1, 1'b1});
    // gap-out after 7 green cycles
    tbl.push_back('{1'b0, 4'b0010,  6, 8'h08, 2'd1, 1'b0});
    tbl.push_back('{1'b0, 4'b0000,  2, 8'h04, 2'd1, 1'b0});
    tbl.push_back('{1'b0, 4'b0000,  4, 8'h00, 2'd1, 1'b0});
    // rest-in-green on approach 1, competitor raised at green cycle 30
    tbl.push_back('{1'b1, 4'b0000,  1, 8'h00, 2'd3, 1'b0});
    tbl.push_back('{1'b0, 4'b0010,  2, 8'h00, 2'd3, 1'b0});
    tbl.push_back('{1'b0, 4'b0010,  1, 8'h08, 2'd1, 1'b1});
    tbl.push_back('{1'b0, 4'b0010, 29, 8'h08, 2'd1, 1'b0});
    tbl.push_back('{1'b0, 4'b1010,  2, 8'h04, 2'd1, 1'b0});
    tbl.push_back('{1'b0, 4'b1010,  3, 8'h00, 2'd1, 1'b0});
    tbl.push_back('{1'b0, 4'b1010,  1, 8'h80, 2'd3, 1'b1});

    foreach (tbl[s]) begin
      for (int c = 0; c < tbl[s].n; c++) begin
        step(tbl[s].rst, tbl[s].req,
             '{tbl[s].lights, tbl[s].grant, (c == 0) ? tbl[s].ps : 1'b0},
             $sformatf("seg%0d.%0d", s, c));
      end
    end

    // reset in green cycle 3 of approach 3: no yellow, next grant is approach 0
    step(1'b0, 4'b1010, '{8'h80, 2'd3, 1'b0}, "mid_g2");
    step(1'b0, 4'b1010, '{8'h80, 2'd3, 1'b0}, "mid_g3");
    step(1'b1, 4'b1010, '{8'h00, 2'd3, 1'b0}, "mid_reset");
    step(1'b0, 4'b1111, '{8'h00, 2'd3, 1'b0}, "mid_ar0");
    step(1'b0, 4'b1111, '{8'h00, 2'd3, 1'b0}, "mid_ar1");
    step(1'b0, 4'b1111, '{8'h02, 2'd0, 1'b1}, "mid_next_grant");
    step(1'b0, 4'b1111, '{8'h02, 2'd0, 1'b0}, "mid_green2");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/intersection_phase_scheduler.md
# intersection_phase_scheduler

Sequences the green phase of an N-approach signalized intersection. Each approach raises a vehicle-detect request and the block grants green to one approach at a time, in round-robin order. Every phase runs minimum-green, maximum-green, yellow and all-red clearance intervals. The block drives one 2-bit signal head per approach, using the same encoding as the existing highway/country-road signal controller: RED=0, YELLOW=1, GREEN=2.

## Interface
Parameters:
- NUM_APPR, 4: number of approaches (2..8).
- TW, 8: width of the interval counter.
- MIN_GREEN, 5: minimum green length in cycles (≥1).
- MAX_GREEN, 20: green length in cycles after which a competing request forces termination (≥MIN_GREEN).
- YELLOW_T, 2: yellow length in cycles (≥1).
- ALLRED_T, 3: all-red clearance length in cycles (≥1).

Ports:
- clk  in  1  clock. All state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- req  in  NUM_APPR  level vehicle-detect request per approach.
- lights  out  2*NUM_APPR  registered head for approach i at bits [2i+1:2i].
- grant_idx  out  $clog2(NUM_APPR)  approach currently green or yellow; holds the last value while all-red.
- phase_start  out  1  one-cycle pulse in the first cycle a new green is visible.
- preempt  in  1  emergency preemption request (PREEMPT_EN only).
- preempt_idx  in  $clog2(NUM_APPR)  approach to preempt to (PREEMPT_EN only).

## Operation
States: ALLRED, GREEN, YELLOW. `cnt` clears on every state entry and increments by 1 each cycle, saturating at 2^TW-1.

Reset values:
- state=ALLRED, cnt=0, cur=NUM_APPR-1 (so the first search starts at approach 0).
- lights all RED (0), grant_idx=NUM_APPR-1, phase_start=0.

ALLRED:
- All heads are RED.
- Arbitration runs once cnt ≥ ALLRED_T-1.
- Search order is cur+1, cur+2, … with wrap-around modulo NUM_APPR. cur itself is checked last.
- If a request is found: cur ← winner and the state becomes GREEN.
- If no request is found: stay in ALLRED (idle) and re-arbitrate every cycle.

GREEN:
- Head cur is GREEN; all others are RED.
- Let n = cnt+1, the number of green cycles shown so far.
- Go to YELLOW when n ≥ MIN_GREEN and req[cur]=0.
- Also go to YELLOW when n ≥ MAX_GREEN and any req[j]=1 with j≠cur.
- Otherwise hold GREEN indefinitely (rest-in-green while uncontested).

YELLOW:
- Head cur is YELLOW for exactly YELLOW_T cycles, then the state becomes ALLRED.

Simultaneous events:
- A request dropping in the same cycle as MAX_GREEN expiry gives a single transition to YELLOW.
- Request changes during YELLOW and ALLRED are ignored until arbitration.

Reset mid-phase: returns to the reset values on the next edge, with no yellow interval.

Invariant: at most one head is non-RED at any time.

## Timing
- A request asserted while the block idles in ALLRED with cnt ≥ ALLRED_T-1 shows GREEN on the next edge, together with phase_start.
- Full phase cycle time for an uncontested single request: MIN_GREEN + YELLOW_T + ALLRED_T cycles from the first green cycle to the next possible green.
- An ungapped request against continuous competition gets exactly MAX_GREEN green cycles.
- All outputs are registered. There is no combinational path from req to lights.

## Configuration
PREEMPT_EN:
- When defined:
  - preempt and preempt_idx ports exist.
  - During GREEN with preempt=1 and preempt_idx≠cur, the state goes to YELLOW on the next edge, ignoring MIN_GREEN.
  - During GREEN with preempt=1 and preempt_idx=cur, green holds, ignoring MAX_GREEN.
  - At ALLRED arbitration with preempt=1, preempt_idx wins over round-robin, even when req[preempt_idx]=0.
  - YELLOW_T and ALLRED_T are never shortened.
- When undefined: the ports are absent and the behaviour is pure round-robin as described above.

## Test plan
Default parameters unless noted.
- **Reset:** hold reset 2 cycles, req=0 → lights=0, phase_start=0, grant_idx=3; idles in all-red indefinitely.
- **Single request:** req[2] pulsed for 1 cycle after ALLRED expiry → approach 2 GREEN for exactly 5 cycles, YELLOW 2 cycles, all-red 3 cycles; phase_start pulses once.
- **Round-robin:** req=4'b1011 held constant → grant order 0,1,3,0; each green lasts 20 cycles; never two non-RED heads.
- **Rest-in-green:** req[1] held with others 0 → green beyond 20 cycles; raise req[3] at green cycle 30 → YELLOW on the next edge.
- **Reset mid-phase:** reset during GREEN cycle 3 → all RED next edge and grant_idx=3; the next grant is approach 0.
- **Preempt (PREEMPT_EN):** approach 0 green at cycle 1, then preempt=1 with preempt_idx=2 → YELLOW next edge, then 2 YELLOW + 3 all-red cycles, then approach 2 green; held beyond MAX_GREEN while preempt=1 and req[0]=1.
